// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: sequencer states and the
// architectural constants used by hazard detection and pipeline flushing.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } pipe_state_t;

    // $zero never carries a real dependency.
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    // Instruction word loaded into IF/ID on a flush.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Purely combinational so the forwarding unit can
// share it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_hazard
);

    logic w_dst_live;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_dst_live = i_ex_mem_read && (i_ex_rt != REG_ZERO);
    assign w_rs_hit   = (i_ex_rt == i_id_rs);
    assign w_rt_hit   = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_hazard   = w_dst_live && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: resolves load-use stalls, branch
// and jump flushes and data-memory wait states into the pipeline register
// enables, counts stalled cycles and flags a data-memory timeout.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_br_taken,
    input  logic             id_jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    localparam int unsigned      WC_W      = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0]  WAIT_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_next;
    logic             r_mem_timeout;
    logic             w_timeout_set;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;

    load_use_detect u_load_use (
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rt       (ex_rt),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rt  (id_uses_rt),
        .o_hazard      (w_load_use)
    );

    // Next state, wait count and all pipeline enables; reset overrides
    // everything combinationally so outputs react without waiting for a clock.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        w_next_state  = r_state;
        w_wait_next   = r_wait_cnt;
        w_timeout_set = 1'b0;

        if (!rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
            w_next_state = ST_RUN;
            w_wait_next  = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_write  = 1'b0;
                        w_next_state = ST_MEM_WAIT;
                        w_wait_next  = WAIT_ONE;
                    end else if (ex_br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        w_next_state = ST_RUN;
                        w_wait_next  = '0;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        exmem_write = 1'b0;
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_timeout_set = 1'b1;
                            w_next_state  = ST_ERROR;
                        end else begin
                            w_wait_next = r_wait_cnt + WAIT_ONE;
                        end
                    end
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_write = 1'b0;
                end
            endcase
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_mem_timeout;

endmodule
